// File: rtl/esp32_prog_ctrl.sv
// ---------------------------------------------------------------------------
// esp32_prog_ctrl
// Turns the FTDI DTR/RTS modem-control handshake into ESP32 EN/GPIO0 drive
// (esptool auto-reset mapping), tracks bootloader sessions so the top can
// release the SD/GPIO lines, and raises a debounced FPGA reload request when
// button 0 is held long enough.
//
// Ports
//   clk_25mhz      in   only clock
//   reset          in   synchronous, active-high
//   ftdi_ndtr      in   async, active-low DTR
//   ftdi_nrts      in   async, active-low RTS
//   btn0           in   async, active-low button (low = pressed)
//   en_o           out  ESP32 EN drive level
//   gpio0_o        out  ESP32 GPIO0 drive level
//   prog_active    out  bootloader session in progress
//   sd_release     out  high = release SD/GPIO lines to hi-z
//   user_programn  out  low = FPGA reload request (sticky until reset)
//   state_o        out  FSM state for LEDs: 0 IDLE, 1 PWRUP, 2 PROG
// ---------------------------------------------------------------------------
module esp32_prog_ctrl #(
   parameter int unsigned C_powerup_en_time      = 0,
   parameter int unsigned C_prog_release_timeout = 26,
   parameter int unsigned C_progndelay           = 16
) (
   input  logic       clk_25mhz,
   input  logic       reset,
   input  logic       ftdi_ndtr,
   input  logic       ftdi_nrts,
   input  logic       btn0,
   output logic       en_o,
   output logic       gpio0_o,
   output logic       prog_active,
   output logic       sd_release,
   output logic       user_programn,
   output logic [1:0] state_o
);

   localparam int unsigned PWR_W     = (C_powerup_en_time > 0) ? C_powerup_en_time : 1;
   localparam int unsigned TMR_W     = C_prog_release_timeout;
   localparam int unsigned HOLD_W    = C_progndelay + 1;
   localparam logic        HAS_PWRUP = (C_powerup_en_time > 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PWRUP = 2'd1,
      ST_PROG  = 2'd2
   } state_t;

   localparam state_t ST_RESET = state_t'(HAS_PWRUP ? 2'd1 : 2'd0);

   // Synchronizer stages; reset to the inactive (high) pin level.
   logic ndtr_m, ndtr_s;
   logic nrts_m, nrts_s;
   logic btn_m,  btn_s;

   // Decoded boot-pin levels, their registered copies and the previous copies.
   logic en_raw_c, g0_raw_c;
   logic en_q, g0_q;
   logic en_prev, g0_prev;
   logic rise_c, change_c;

   state_t             state, state_n;
   logic [PWR_W-1:0]   pwr_cnt, pwr_cnt_n;
   logic [TMR_W-1:0]   tmr, tmr_n;
   logic               en_n, g0_n, active_n;
   logic [HOLD_W-1:0]  hold_cnt;

   // 2-FF synchronizers for the asynchronous pins.
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         ndtr_m <= 1'b1;
         ndtr_s <= 1'b1;
         nrts_m <= 1'b1;
         nrts_s <= 1'b1;
         btn_m  <= 1'b1;
         btn_s  <= 1'b1;
      end else begin
         ndtr_m <= ftdi_ndtr;
         ndtr_s <= ndtr_m;
         nrts_m <= ftdi_nrts;
         nrts_s <= nrts_m;
         btn_m  <= btn0;
         btn_s  <= btn_m;
      end
   end

   // esptool mapping: RTS alone pulls EN low, DTR alone pulls GPIO0 low.
   always_comb begin
      en_raw_c = ~(~nrts_s & ndtr_s);
      g0_raw_c = ~(~ndtr_s & nrts_s);
   end

   // Registered pin levels plus one cycle of history for edge/change detection.
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         en_q    <= 1'b1;
         g0_q    <= 1'b1;
         en_prev <= 1'b1;
         g0_prev <= 1'b1;
      end else begin
         en_q    <= en_raw_c;
         g0_q    <= g0_raw_c;
         en_prev <= en_q;
         g0_prev <= g0_q;
      end
   end

   // Bootloader entry is EN rising while GPIO0 is held low.
   always_comb begin
      rise_c   = en_q & ~en_prev & ~g0_q;
      change_c = (en_q ^ en_prev) | (g0_q ^ g0_prev);
   end

   // Next-state, counters and next output values.
   always_comb begin
      state_n   = state;
      pwr_cnt_n = pwr_cnt;
      tmr_n     = tmr;
      case (state)
         ST_PWRUP: begin
            pwr_cnt_n = pwr_cnt + PWR_W'(1);
            if (pwr_cnt == '1) begin
               state_n   = ST_IDLE;
               pwr_cnt_n = '0;
            end
         end
         ST_IDLE: begin
            tmr_n = '0;
            if (rise_c) begin
               state_n = ST_PROG;
               tmr_n   = '1;
            end
         end
         ST_PROG: begin
            // Any boot-pin activity restarts the release window, even at zero.
            if (change_c) begin
               tmr_n = '1;
            end else if (tmr == '0) begin
               state_n = ST_IDLE;
            end else begin
               tmr_n = tmr - TMR_W'(1);
            end
         end
         default: begin
            state_n = ST_IDLE;
            tmr_n   = '0;
         end
      endcase

      en_n     = en_raw_c;
      g0_n     = g0_raw_c;
      active_n = (state_n == ST_PROG);
      if (state_n == ST_PWRUP) begin
         en_n = 1'b0;
         g0_n = 1'b1;
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         state       <= ST_RESET;
         pwr_cnt     <= '0;
         tmr         <= '0;
         en_o        <= ~HAS_PWRUP;
         gpio0_o     <= 1'b1;
         prog_active <= 1'b0;
         sd_release  <= 1'b0;
      end else begin
         state       <= state_n;
         pwr_cnt     <= pwr_cnt_n;
         tmr         <= tmr_n;
         en_o        <= en_n;
         gpio0_o     <= g0_n;
         prog_active <= active_n;
         sd_release  <= active_n;
      end
   end

   assign state_o = 2'(state);

   // Button hold counter; saturates at the MSB, request is sticky until reset.
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         hold_cnt      <= '0;
         user_programn <= 1'b1;
      end else begin
         if (btn_s) begin
            hold_cnt <= '0;
         end else if (!hold_cnt[HOLD_W-1]) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
         if (hold_cnt[HOLD_W-1]) begin
            user_programn <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_esp32_prog_ctrl.sv
// ---------------------------------------------------------------------------
// tb_esp32_prog_ctrl
// Self-checking bench for esp32_prog_ctrl with short timing parameters.
// The reference model keeps the driven pin history per cycle and derives the
// expected outputs from pin delays, a session deadline and a low-run length.
// ---------------------------------------------------------------------------
module tb_esp32_prog_ctrl;

   localparam int unsigned PW = 3;
   localparam int unsigned RT = 4;
   localparam int unsigned PD = 3;
   localparam int PW_CYC = 1 << PW;
   localparam int RT_CYC = 1 << RT;
   localparam int PD_CYC = 1 << PD;

   logic       clk_25mhz = 1'b0;
   logic       reset     = 1'b1;
   logic       ftdi_ndtr = 1'b1;
   logic       ftdi_nrts = 1'b1;
   logic       btn0      = 1'b1;
   logic       en_o, gpio0_o, prog_active, sd_release, user_programn;
   logic [1:0] state_o;

   always #5 clk_25mhz = ~clk_25mhz;

   esp32_prog_ctrl #(
      .C_powerup_en_time      (PW),
      .C_prog_release_timeout (RT),
      .C_progndelay           (PD)
   ) dut (
      .clk_25mhz     (clk_25mhz),
      .reset         (reset),
      .ftdi_ndtr     (ftdi_ndtr),
      .ftdi_nrts     (ftdi_nrts),
      .btn0          (btn0),
      .en_o          (en_o),
      .gpio0_o       (gpio0_o),
      .prog_active   (prog_active),
      .sd_release    (sd_release),
      .user_programn (user_programn),
      .state_o       (state_o)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: pin history since the last reset edge, indexed by cycle.
   int k = 0;
   bit h_en[$];
   bit h_g0[$];
   bit h_btn[$];
   int m_mode = 1;      // 0 IDLE, 1 PWRUP, 2 PROG
   int m_deadline = 0;  // edge at which an idle PROG session ends
   int m_run = 0;       // consecutive pressed cycles seen by the hold logic
   bit m_upn = 1'b1;
   bit m_en = 1'b0;
   bit m_g0 = 1'b1;

   function automatic bit raw_en(int j);
      if (j < 0 || j >= h_en.size()) return 1'b1;
      return h_en[j];
   endfunction

   function automatic bit raw_g0(int j);
      if (j < 0 || j >= h_g0.size()) return 1'b1;
      return h_g0[j];
   endfunction

   function automatic bit raw_btn(int j);
      if (j < 0 || j >= h_btn.size()) return 1'b1;
      return h_btn[j];
   endfunction

   function automatic void model_edge();
      if (reset) begin
         k = 0;
         h_en.delete();
         h_g0.delete();
         h_btn.delete();
         m_mode     = 1;
         m_deadline = 0;
         m_run      = 0;
         m_upn      = 1'b1;
      end else begin
         k++;
         case (m_mode)
            1: if (k >= PW_CYC) m_mode = 0;
            0: if (raw_en(k-4) && !raw_en(k-5) && !raw_g0(k-4)) begin
                  m_mode     = 2;
                  m_deadline = k + RT_CYC;
               end
            default: begin
               if (raw_en(k-4) != raw_en(k-5) || raw_g0(k-4) != raw_g0(k-5))
                  m_deadline = k + RT_CYC;
               else if (k >= m_deadline)
                  m_mode = 0;
            end
         endcase
         if (m_run >= PD_CYC) m_upn = 1'b0;
         m_run = raw_btn(k-3) ? 0 : m_run + 1;
      end
      m_en = (m_mode == 1) ? 1'b0 : raw_en(k-3);
      m_g0 = (m_mode == 1) ? 1'b1 : raw_g0(k-3);
   endfunction

   // Drive pins for one cycle, advance the model at the edge, return at negedge.
   task automatic cycle(input bit nd, input bit nr, input bit b);
      bit dtr, rts;
      ftdi_ndtr = nd;
      ftdi_nrts = nr;
      btn0      = b;
      dtr = !nd;
      rts = !nr;
      h_en.push_back(!(rts && !dtr));
      h_g0.push_back(!(dtr && !rts));
      h_btn.push_back(b);
      @(posedge clk_25mhz);
      model_edge();
      @(negedge clk_25mhz);
   endtask

   // Park in IDLE with EN low, then apply DTR-only; n = cycles until prog_active.
   task automatic enter_prog(output int n);
      int i;
      i = 0;
      n = -1;
      while (i < 60 && !(i >= 6 && prog_active === 1'b0 && state_o === 2'd0)) begin
         cycle(1'b1, 1'b0, 1'b1);
         i++;
      end
      for (int c = 1; c <= 12 && n < 0; c++) begin
         cycle(1'b0, 1'b1, 1'b1);
         if (prog_active === 1'b1) n = c;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);
      reset = 1'b0;
      tests++; if (en_o !== 1'b0) begin fails++; $display("FAIL reset_en_o: got %b expected 0", en_o); end
      tests++; if (gpio0_o !== 1'b1) begin fails++; $display("FAIL reset_gpio0_o: got %b expected 1", gpio0_o); end
      tests++; if (prog_active !== 1'b0) begin fails++; $display("FAIL reset_prog_active: got %b expected 0", prog_active); end
      tests++; if (sd_release !== 1'b0) begin fails++; $display("FAIL reset_sd_release: got %b expected 0", sd_release); end
      tests++; if (user_programn !== 1'b1) begin fails++; $display("FAIL reset_user_programn: got %b expected 1", user_programn); end
      tests++; if (state_o !== 2'd1) begin fails++; $display("FAIL reset_state_o: got %0d expected 1", state_o); end
   endtask

   task automatic test_powerup();
      int first_hi;
      first_hi = -1;
      for (int i = 1; i <= 12; i++) begin
         cycle(1'b1, 1'b1, 1'b1);
         tests++; if (en_o !== m_en) begin fails++; $display("FAIL pwrup_en_o cyc %0d: got %b expected %b", i, en_o, m_en); end
         tests++; if (gpio0_o !== 1'b1) begin fails++; $display("FAIL pwrup_gpio0_o cyc %0d: got %b expected 1", i, gpio0_o); end
         tests++; if (state_o !== 2'(m_mode)) begin fails++; $display("FAIL pwrup_state_o cyc %0d: got %0d expected %0d", i, state_o, m_mode); end
         if (en_o === 1'b1 && first_hi < 0) first_hi = i;
      end
      tests++; if (first_hi != PW_CYC) begin fails++; $display("FAIL pwrup_hold_len: en_o rose at %0d expected %0d", first_hi, PW_CYC); end
   endtask

   task automatic test_autoreset();
      int rise;
      rise = -1;
      for (int i = 1; i <= 6; i++) begin
         cycle(1'b1, 1'b0, 1'b1);
         tests++; if (en_o !== m_en || gpio0_o !== m_g0) begin fails++; $display("FAIL autoreset_rts_phase cyc %0d: got en=%b g0=%b expected en=%b g0=%b", i, en_o, gpio0_o, m_en, m_g0); end
      end
      tests++; if (en_o !== 1'b0) begin fails++; $display("FAIL autoreset_en_low: got %b expected 0", en_o); end
      for (int i = 1; i <= 12; i++) begin
         cycle(1'b0, 1'b1, 1'b1);
         tests++; if (prog_active !== (m_mode == 2)) begin fails++; $display("FAIL autoreset_prog_active cyc %0d: got %b expected %b", i, prog_active, (m_mode == 2)); end
         if (prog_active === 1'b1 && rise < 0) begin
            rise = i;
            tests++; if (en_o !== 1'b1 || gpio0_o !== 1'b0) begin fails++; $display("FAIL autoreset_pins_at_entry: got en=%b g0=%b expected en=1 g0=0", en_o, gpio0_o); end
         end
      end
      tests++; if (rise != 4) begin fails++; $display("FAIL autoreset_latency: got %0d expected 4", rise); end
   endtask

   task automatic test_release();
      int n, fall;
      enter_prog(n);
      tests++; if (n != 4) begin fails++; $display("FAIL release_entry: got %0d expected 4", n); end
      fall = -1;
      for (int i = 1; i <= 40 && fall < 0; i++) begin
         cycle(1'b0, 1'b1, 1'b1);
         tests++; if (prog_active !== (m_mode == 2) || sd_release !== (m_mode == 2)) begin fails++; $display("FAIL release_steady cyc %0d: got pa=%b sd=%b expected %b", i, prog_active, sd_release, (m_mode == 2)); end
         if (prog_active === 1'b0) fall = i;
      end
      tests++; if (fall != RT_CYC) begin fails++; $display("FAIL release_timeout: fell at %0d expected %0d", fall, RT_CYC); end
      tests++; if (state_o !== 2'd0) begin fails++; $display("FAIL release_state_idle: got %0d expected 0", state_o); end

      // Activity landing exactly on the zero count must restart the window.
      enter_prog(n);
      tests++; if (n != 4) begin fails++; $display("FAIL reload_entry: got %0d expected 4", n); end
      fall = -1;
      for (int c = 1; c <= 40 && fall < 0; c++) begin
         if (c < 13) cycle(1'b0, 1'b1, 1'b1);
         else        cycle(1'b1, 1'b1, 1'b1);
         tests++; if (prog_active !== (m_mode == 2)) begin fails++; $display("FAIL reload_prog_active cyc %0d: got %b expected %b", c, prog_active, (m_mode == 2)); end
         if (prog_active === 1'b0) fall = c;
      end
      tests++; if (fall != 2 * RT_CYC) begin fails++; $display("FAIL reload_at_zero: fell at %0d expected %0d", fall, 2 * RT_CYC); end
   endtask

   task automatic test_no_false_entry();
      for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b0, 1'b1);
      for (int i = 1; i <= 12; i++) begin
         cycle(1'b1, 1'b1, 1'b1);
         tests++; if (prog_active !== 1'b0) begin fails++; $display("FAIL nofalse_prog_active cyc %0d: got %b expected 0", i, prog_active); end
         tests++; if (en_o !== m_en) begin fails++; $display("FAIL nofalse_en_o cyc %0d: got %b expected %b", i, en_o, m_en); end
      end
      tests++; if (en_o !== 1'b1 || gpio0_o !== 1'b1) begin fails++; $display("FAIL nofalse_final_pins: got en=%b g0=%b expected en=1 g0=1", en_o, gpio0_o); end
   endtask

   task automatic test_button();
      int low;
      for (int i = 1; i <= 7; i++) cycle(1'b1, 1'b1, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         cycle(1'b1, 1'b1, 1'b1);
         tests++; if (user_programn !== 1'b1) begin fails++; $display("FAIL button_short_press cyc %0d: got %b expected 1", i, user_programn); end
      end
      low = -1;
      for (int i = 1; i <= 12; i++) begin
         cycle(1'b1, 1'b1, 1'b0);
         tests++; if (user_programn !== m_upn) begin fails++; $display("FAIL button_long_press cyc %0d: got %b expected %b", i, user_programn, m_upn); end
         if (user_programn === 1'b0 && low < 0) low = i;
      end
      tests++; if (low != 2 + PD_CYC + 1) begin fails++; $display("FAIL button_latency: got %0d expected %0d", low, 2 + PD_CYC + 1); end
      for (int i = 1; i <= 5; i++) begin
         cycle(1'b1, 1'b1, 1'b1);
         tests++; if (user_programn !== 1'b0) begin fails++; $display("FAIL button_sticky cyc %0d: got %b expected 0", i, user_programn); end
      end
      reset = 1'b1;
      cycle(1'b1, 1'b1, 1'b1);
      reset = 1'b0;
      tests++; if (user_programn !== 1'b1) begin fails++; $display("FAIL button_reset_clears: got %b expected 1", user_programn); end
   endtask

   task automatic test_reset_mid_prog();
      int n, first_hi;
      enter_prog(n);
      tests++; if (n != 4) begin fails++; $display("FAIL midprog_entry: got %0d expected 4", n); end
      for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, 1'b1);
      reset = 1'b1;
      cycle(1'b0, 1'b1, 1'b1);
      reset = 1'b0;
      tests++; if (prog_active !== 1'b0 || sd_release !== 1'b0) begin fails++; $display("FAIL midprog_release: got pa=%b sd=%b expected 0", prog_active, sd_release); end
      tests++; if (en_o !== 1'b0) begin fails++; $display("FAIL midprog_en_o: got %b expected 0", en_o); end
      tests++; if (state_o !== 2'd1) begin fails++; $display("FAIL midprog_state_o: got %0d expected 1", state_o); end
      first_hi = -1;
      for (int i = 1; i <= 12; i++) begin
         cycle(1'b1, 1'b1, 1'b1);
         tests++; if (en_o !== m_en || state_o !== 2'(m_mode)) begin fails++; $display("FAIL midprog_pwrup cyc %0d: got en=%b st=%0d expected en=%b st=%0d", i, en_o, state_o, m_en, m_mode); end
         if (en_o === 1'b1 && first_hi < 0) first_hi = i;
      end
      tests++; if (first_hi != PW_CYC) begin fails++; $display("FAIL midprog_hold_len: en_o rose at %0d expected %0d", first_hi, PW_CYC); end
   endtask

   task automatic test_random();
      bit nd, nr, b;
      int hold_p, hold_b;
      nd = 1'b1; nr = 1'b1; b = 1'b1;
      hold_p = 0; hold_b = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold_p == 0) begin
            {nd, nr} = 2'($urandom_range(0, 3));
            hold_p   = $urandom_range(1, 24);
         end
         if (hold_b == 0) begin
            b      = ($urandom_range(0, 3) != 0);
            hold_b = $urandom_range(1, 12);
         end
         hold_p--;
         hold_b--;
         reset = ($urandom_range(0, 299) == 0);
         cycle(nd, nr, b);
         reset = 1'b0;
         tests++; if (en_o !== m_en) begin fails++; $display("FAIL rand_en_o cyc %0d: got %b expected %b", i, en_o, m_en); end
         tests++; if (gpio0_o !== m_g0) begin fails++; $display("FAIL rand_gpio0_o cyc %0d: got %b expected %b", i, gpio0_o, m_g0); end
         tests++; if (prog_active !== (m_mode == 2)) begin fails++; $display("FAIL rand_prog_active cyc %0d: got %b expected %b", i, prog_active, (m_mode == 2)); end
         tests++; if (sd_release !== (m_mode == 2)) begin fails++; $display("FAIL rand_sd_release cyc %0d: got %b expected %b", i, sd_release, (m_mode == 2)); end
         tests++; if (user_programn !== m_upn) begin fails++; $display("FAIL rand_user_programn cyc %0d: got %b expected %b", i, user_programn, m_upn); end
         tests++; if (state_o !== 2'(m_mode)) begin fails++; $display("FAIL rand_state_o cyc %0d: got %0d expected %0d", i, state_o, m_mode); end
      end
   endtask

   initial begin
      test_reset();
      test_powerup();
      test_autoreset();
      test_release();
      test_no_false_entry();
      test_button();
      test_reset_mid_prog();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
